// File: rtl/posit_pkg.sv
// ============================================================================
// Module : posit_pkg
// Brief  : Shared widths and the 21-bit unpacked float format for posit<8,0>.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package posit_pkg;

    localparam int N        = 8;
    localparam int ES       = 0;
    localparam int EXP_W    = 5;
    localparam int EXP_BIAS = 15;
    localparam int FRAC_W   = 13;

    localparam int NAR_BIT  = 20;
    localparam int ZERO_BIT = 19;
    localparam int SIGN_BIT = 18;

    typedef struct packed {
        logic              nar;
        logic              zero;
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [FRAC_W-1:0] fraction;
    } posit_unpacked_t;

endpackage

`default_nettype wire

// File: rtl/posit8_decode.sv
// ============================================================================
// Module : posit8_decode
// Brief  : Splits a posit<8,0> into flags, sign, regime exponent and fraction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module posit8_decode
    import posit_pkg::*;
(
    input  logic [N-1:0]      posit,
    output logic              is_nar,
    output logic              is_zero,
    output logic              sign,
    output logic signed [3:0] exponent,
    output logic [4:0]        fraction
);

    logic [N-1:0] w_mag;
    logic [6:0]   w_body;
    logic         w_lead;
    logic [2:0]   w_run;
    logic         w_done;
    logic [11:0]  w_ext;

    always_comb begin
        is_zero = (posit == 8'h00);
        is_nar  = (posit == 8'h80);
        sign    = posit[N-1];
        w_mag   = sign ? (~posit + 8'd1) : posit;
        w_body  = w_mag[6:0];
        w_lead  = w_body[6];

        // Regime run: count identical leading bits below the sign bit.
        w_run  = 3'd0;
        w_done = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!w_done && (w_body[i] == w_lead))
                w_run = w_run + 3'd1;
            else
                w_done = 1'b1;
        end

        // Drop the run and its terminating bit; what remains is the fraction.
        w_ext    = {w_body, 5'b0} << ({1'b0, w_run} + 4'd1);
        fraction = w_ext[11:7];
        exponent = w_lead ? ($signed({1'b0, w_run}) - 4'sd1)
                          : (-$signed({1'b0, w_run}));
    end

endmodule

`default_nettype wire

// File: rtl/clocked_mult_8bit.sv
// ============================================================================
// Module : clocked_mult_8bit
// Brief  : Exact registered posit<8,0> multiplier producing the unpacked format.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clocked_mult_8bit
    import posit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      left_posit,
    input  logic [N-1:0]      right_posit,
    output logic [20:0]       result
);

    logic              w_l_nar, w_l_zero, w_l_sign;
    logic              w_r_nar, w_r_zero, w_r_sign;
    logic signed [3:0] w_l_exp, w_r_exp;
    logic [4:0]        w_l_frac, w_r_frac;

    logic [11:0]       w_prod;
    logic [4:0]        w_exp_sum;
    logic [10:0]       w_m;
    logic [12:0]       w_frac13;
    logic [4:0]        w_e;
    posit_unpacked_t   w_next;
    posit_unpacked_t   r_result;

    posit8_decode u_dec_left (
        .posit    (left_posit),
        .is_nar   (w_l_nar),
        .is_zero  (w_l_zero),
        .sign     (w_l_sign),
        .exponent (w_l_exp),
        .fraction (w_l_frac)
    );

    posit8_decode u_dec_right (
        .posit    (right_posit),
        .is_nar   (w_r_nar),
        .is_zero  (w_r_zero),
        .sign     (w_r_sign),
        .exponent (w_r_exp),
        .fraction (w_r_frac)
    );

    always_comb begin
        w_prod    = {6'b0, 1'b1, w_l_frac} * {6'b0, 1'b1, w_r_frac};
        w_exp_sum = {w_l_exp[3], w_l_exp} + {w_r_exp[3], w_r_exp} + {4'b0, w_prod[11]};
        w_m       = w_prod[11] ? w_prod[10:0] : {w_prod[9:0], 1'b0};
        w_frac13  = {w_m, 2'b00};

        w_next      = '0;
        w_next.sign = w_l_sign ^ w_r_sign;
        if (w_next.sign) begin
            // value = (-2 + f) * 2^e; an exact power of two borrows from e.
            w_e             = w_exp_sum - {4'b0, (w_m == 11'd0)};
            w_next.fraction = ~w_frac13 + 13'd1;
        end else begin
            w_e             = w_exp_sum;
            w_next.fraction = w_frac13;
        end
        w_next.exponent = w_e + 5'(EXP_BIAS);

        if (w_l_nar || w_r_nar) begin
            w_next     = '0;
            w_next.nar = 1'b1;
        end else if (w_l_zero || w_r_zero) begin
            w_next      = '0;
            w_next.zero = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_result <= '0;
        else
            r_result <= w_next;
    end

    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_clocked_mult_8bit.sv
// ============================================================================
// Module : tb_clocked_mult_8bit
// Brief  : Directed-vector bench for the registered posit<8,0> multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clocked_mult_8bit;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [20:0] exp;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  left_posit;
    logic [7:0]  right_posit;
    logic [20:0] result;

    int errors = 0;
    int checks = 0;

    vec_t vecs[16];

    clocked_mult_8bit dut (
        .clk         (clk),
        .rst         (rst),
        .left_posit  (left_posit),
        .right_posit (right_posit),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h20, 8'h60, 21'h01E000, "half_x_two"};
        vecs[1]  = '{8'h66, 8'hdb, 21'h05ED20, "neg_frac"};
        vecs[2]  = '{8'h8f, 8'h3a, 21'h063F60, "neg_norm_shift"};
        vecs[3]  = '{8'hb2, 8'he2, 21'h01CB20, "neg_x_neg"};
        vecs[4]  = '{8'h00, 8'h66, 21'h080000, "zero_left"};
        vecs[5]  = '{8'h80, 8'h00, 21'h100000, "nar_dominates"};
        vecs[6]  = '{8'h40, 8'hC0, 21'h05C000, "neg_pow2"};
        vecs[7]  = '{8'h7F, 8'h7F, 21'h036000, "maxpos_sq"};
        vecs[8]  = '{8'h7F, 8'h01, 21'h01E000, "max_x_min"};
        vecs[9]  = '{8'h01, 8'h01, 21'h006000, "minpos_sq"};
        vecs[10] = '{8'h66, 8'h80, 21'h100000, "nar_right"};
        vecs[11] = '{8'hC0, 8'hC0, 21'h01E000, "negone_sq"};
        vecs[12] = '{8'h7F, 8'hC0, 21'h068000, "neg_64"};
        vecs[13] = '{8'h81, 8'h81, 21'h036000, "negmax_sq"};
        vecs[14] = '{8'h60, 8'h60, 21'h022000, "two_sq"};
        vecs[15] = '{8'h3a, 8'h00, 21'h080000, "zero_right"};

        rst         = 1'b0;
        left_posit  = 8'h66;
        right_posit = 8'h66;
        @(posedge clk); #1;
        check("reset_state", result, 21'h000000);

        // Release reset; the very next edge must carry the product.
        @(negedge clk);
        rst         = 1'b1;
        left_posit  = 8'h20;
        right_posit = 8'h60;
        @(posedge clk); #1;
        check("after_release", result, 21'h01E000);

        // Back-to-back table: before each edge the previous product must
        // still be held, after it the new one must appear.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            left_posit  = vecs[i].a;
            right_posit = vecs[i].b;
            #1;
            if (i > 0) check({"hold_", vecs[i-1].name}, result, vecs[i-1].exp);
            @(posedge clk); #1;
            check(vecs[i].name, result, vecs[i].exp);
        end

        // Reset wins over valid new operands mid-stream.
        @(negedge clk);
        rst         = 1'b0;
        left_posit  = 8'h66;
        right_posit = 8'hdb;
        @(posedge clk); #1;
        check("reset_wins", result, 21'h000000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_reset_product", result, 21'h05ED20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clocked_mult_8bit.md
Name: clocked_mult_8bit

Overview:
- Registered multiplier for two 8-bit posits (posit<8,0>, es=0).
- Produces an exact, unrounded product in the team's 21-bit unpacked float format (flags, sign, biased exponent, fraction).
- Sits in the datapath before a downstream rounding and re-packing stage; it never rounds.

Parameters:
- None. Widths are fixed by the shared package: N=8, ES=0, EXP_W=5, EXP_BIAS=15, FRAC_W=13.

Ports:
- clk  input  1  Single clock; rising edge.
- rst  input  1  Reset; synchronous, active-low.
- left_posit  input  8  Left operand, posit<8,0>.
- right_posit  input  8  Right operand, posit<8,0>.
- result  output  21  Unpacked product, registered.

Behaviour:
- Result field layout:
  - [20] NaR flag.
  - [19] zero flag.
  - [18] sign.
  - [17:13] exponent, biased by 15.
  - [12:0] fraction.
- Reset: on a rising clk edge with rst==0, result <= 21'h000000. Reset wins over new data.
- Latency: 1 cycle.
  - Operands are sampled at rising edge t; the product appears on result after edge t.
  - Full throughput, new operands every cycle; no handshake, no stall.
- Decode, per operand:
  - 0x00 is zero.
  - 0x80 is NaR.
  - Otherwise, negative operands are two's-complemented to magnitude.
  - Regime run length gives k, with range -6..6. The exponent equals k (es=0).
  - The remaining bits, up to 5, are the fraction F, left-aligned, with hidden 1.
- Special cases:
  - Either operand NaR: result = {1,0,19'b0}. NaR dominates zero.
  - Else either operand zero: result = {0,1,19'b0}.
- Normal path:
  - sign = sL XOR sR.
  - Compute the 6x6 mantissa product (1.FL)*(1.FR), range [1,4).
  - If the product is >=2: shift right by 1 and E = eL+eR+1; otherwise E = eL+eR.
  - Magnitude = (1+M)*2^E with M exact in 11 bits, placed in fraction[12:2]; the low bits are 0.
  - No rounding is ever needed.
- Positive result: exponent field = E+15, fraction = M.
- Negative result: encode so that value = (-2+f)*2^e (posit-style negative fraction).
  - M != 0: e = E, f = 1-M, i.e. the 13-bit two's complement of M.
  - M == 0 (exact power of two): e = E-1, f = 0.
- Exponent range:
  - E is in -12..13; stored e+15 is in 2..28. No overflow or underflow handling is required.
- No X propagation: all result bits are defined every cycle after reset.

Decomposition:
- Package posit_pkg holds:
  - The constants N, ES, EXP_W, EXP_BIAS, FRAC_W.
  - Flag bit positions.
  - A packed struct for the 21-bit unpacked format.
- Sub-module posit8_decode, instantiated twice:
  - Input: 8-bit posit.
  - Outputs: is_nar, is_zero, sign, signed exponent (4 bits), 5-bit fraction.
- clocked_mult_8bit holds the multiply, normalize and negative-encode logic plus the output register.

Test Plan:
- Reset: hold rst=0 for one edge with arbitrary operands -> result==21'h000000; release rst -> the next edge shows the product.
- 0x20 (0.5) * 0x60 (2.0) -> 1.0 -> result 21'h01E000, checked one cycle after the operands are applied.
- 0x66 (2.75) * 0xdb (-0.578125) -> -1.58984375 -> 21'h05ED20.
- 0x8f (-4.5) * 0x3a (0.90625) -> -4.078125 -> 21'h063F60.
- 0xb2 (-1.4375) * 0xe2 (-0.46875) -> 0.673828125 -> 21'h01CB20.
- Specials and boundaries:
  - 0x00*0x66 -> 21'h080000.
  - 0x80*0x00 -> 21'h100000 (NaR dominates).
  - 0x40 (1.0) * 0xC0 (-1.0) -> 21'h05C000 (power-of-two negative, e=-1, f=0).
  - 0x7F*0x7F (64*64) -> exponent field 27.
  - Back-to-back operand changes every cycle -> each result lags its operands by exactly one cycle.
